// File: rtl/morse_symbol_sequencer_pkg.sv
// Shared definitions for the Morse symbol sequencer: classifier codes, FSM states
// and the gap timer width.
package morse_symbol_sequencer_pkg;

   localparam logic [1:0] SYM_WAIT = 2'b00;
   localparam logic [1:0] SYM_DOT  = 2'b01;
   localparam logic [1:0] SYM_DASH = 2'b10;
   localparam logic [1:0] SYM_SEND = 2'b11;

   localparam int GAP_W = 16;
   localparam logic [GAP_W-1:0] GAP_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_HOLD    = 2'd2
   } seq_state_t;

endpackage

// File: rtl/morse_symbol_sequencer_if.sv
// Symbol input and letter output bundle of the Morse symbol sequencer.
// master = sequencer side, slave = classifier/consumer side.
interface morse_symbol_sequencer_if #(
   parameter int MAX_SYMBOLS = 5
);
   logic [1:0]             sym_code;
   logic                   out_ready;
   logic                   out_valid;
   logic [MAX_SYMBOLS-1:0] out_pattern;
   logic [2:0]             out_len;
   logic                   busy;
   logic                   sym_dropped;
   logic                   overflow;

   modport master (
      input  sym_code, out_ready,
      output out_valid, out_pattern, out_len, busy, sym_dropped, overflow
   );

   modport slave (
      output sym_code, out_ready,
      input  out_valid, out_pattern, out_len, busy, sym_dropped, overflow
   );
endinterface

// File: rtl/morse_gap_timer.sv
// Saturating idle-cycle counter; expired flags that the count has reached
// GAP_CYCLES (never, when GAP_CYCLES is 0).
import morse_symbol_sequencer_pkg::*;

module morse_gap_timer #(
   parameter int GAP_CYCLES = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic tick,
   output logic expired
);

   logic [GAP_W-1:0] gap_cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         gap_cnt <= '0;
      end else if (tick && (gap_cnt != GAP_MAX)) begin
         gap_cnt <= gap_cnt + 1'b1;
      end
   end

   assign expired = (GAP_CYCLES != 0) && (gap_cnt == GAP_W'(GAP_CYCLES));

endmodule

// File: rtl/morse_symbol_sequencer.sv
// Assembles dot/dash symbols into letters and hands them out over a valid/ready
// output, committing on a send code or after an idle gap.
//
//   state      | meaning
//   -----------+---------------------------------------------
//   ST_IDLE    | buffer empty, waiting for the first symbol
//   ST_COLLECT | 1..MAX_SYMBOLS symbols buffered
//   ST_HOLD    | letter presented, out_valid high
import morse_symbol_sequencer_pkg::*;

module morse_symbol_sequencer #(
   parameter int MAX_SYMBOLS = 5,
   parameter int GAP_CYCLES  = 20
) (
   input  logic                     clk,
   input  logic                     rst,
   morse_symbol_sequencer_if.master bus
);

   seq_state_t state_q, state_d;

   logic [MAX_SYMBOLS-1:0] pattern_q, pattern_d;
   logic [2:0]             count_q, count_d;
   logic                   send_run_q;
   logic                   dropped_q;
   logic                   overflow_q;

   logic is_symbol;
   logic is_dash;
   logic send;
   logic full;
   logic drop;
   logic overflow_set;
   logic gap_clear;
   logic gap_tick;
   logic gap_expired;

   assign is_symbol = (bus.sym_code == SYM_DOT) || (bus.sym_code == SYM_DASH);
   assign is_dash   = (bus.sym_code == SYM_DASH);
   // only the first cycle of a run of send codes counts
   assign send      = (bus.sym_code == SYM_SEND) && !send_run_q;
   assign full      = (count_q == 3'(MAX_SYMBOLS));

   morse_gap_timer #(
      .GAP_CYCLES (GAP_CYCLES)
   ) u_gap_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (gap_clear),
      .tick    (gap_tick),
      .expired (gap_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pattern_d    = pattern_q;
      count_d      = count_q;
      drop         = 1'b0;
      overflow_set = 1'b0;
      gap_clear    = 1'b1;
      gap_tick     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (is_symbol) begin
               pattern_d    = '0;
               pattern_d[0] = is_dash;
               count_d      = 3'd1;
               state_d      = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            gap_clear = 1'b0;
            if (send || gap_expired) begin
               // a symbol in the commit cycle cannot join the frozen letter
               state_d      = ST_HOLD;
               gap_clear    = 1'b1;
               drop         = is_symbol;
               overflow_set = is_symbol && full;
            end else if (is_symbol) begin
               if (full) begin
                  drop         = 1'b1;
                  overflow_set = 1'b1;
               end else begin
                  for (int i = 0; i < MAX_SYMBOLS; i++) begin
                     if (i == int'(count_q)) pattern_d[i] = is_dash;
                  end
                  count_d   = count_q + 3'd1;
                  gap_clear = 1'b1;
               end
            end else begin
               gap_tick = (bus.sym_code == SYM_WAIT);
            end
         end
         ST_HOLD: begin
            drop         = is_symbol;
            overflow_set = is_symbol && full;
            if (bus.out_ready) begin
               state_d   = ST_IDLE;
               pattern_d = '0;
               count_d   = '0;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            pattern_d = '0;
            count_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pattern_q  <= '0;
         count_q    <= '0;
         send_run_q <= 1'b0;
         dropped_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         pattern_q  <= pattern_d;
         count_q    <= count_d;
         send_run_q <= (bus.sym_code == SYM_SEND);
         dropped_q  <= drop;
         overflow_q <= overflow_q | overflow_set;
      end
   end

   assign bus.out_valid   = (state_q == ST_HOLD);
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.out_pattern = pattern_q;
   assign bus.out_len     = count_q;
   assign bus.sym_dropped = dropped_q;
   assign bus.overflow    = overflow_q;

endmodule
